portio_ctl: RTL and testbench

- Port I/O controller directly downstream of the czabcd datapath.
- Takes the datapath's port ID and output byte for OUTPUT instructions and posts them to the external peripheral bus through a small write buffer.
- Performs external reads for INPUT instructions and returns the byte on xINPORT_P.
- Stalls CTL while a read is outstanding or while the write buffer is full.

---
 rtl/portio_ctl_if.sv | 27 ++
 rtl/portio_ctl.sv | 161 ++++++++++++++++
 tb/tb_portio_ctl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/portio_ctl_if.sv
// External peripheral bus between portio_ctl (master) and the I/O devices (slave).
interface portio_ctl_if;
  logic [7:0] IO_PORTID;
  logic [7:0] IO_OUT;
  logic       IO_WR;
  logic       IO_RD;
  logic [7:0] IO_IN;
  logic       IO_ACK;

  modport master (
    output IO_PORTID,
    output IO_OUT,
    output IO_WR,
    output IO_RD,
    input  IO_IN,
    input  IO_ACK
  );

  modport slave (
    input  IO_PORTID,
    input  IO_OUT,
    input  IO_WR,
    input  IO_RD,
    output IO_IN,
    output IO_ACK
  );
endinterface

// File: rtl/portio_ctl.sv
// Port I/O controller: buffers OUTPUT writes to the external bus, performs INPUT reads,
// and stalls CTL while a read is outstanding or the write buffer is full.
module portio_ctl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TMO   = 15
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         xOUTPUT_P,
  input  logic         xINPUT_P,
  input  logic [7:0]   xN_P,
  input  logic [7:0]   xPORTID_P,
  input  logic [7:0]   xOUTPORT_P,
  output logic [7:0]   xINPORT_P,
  output logic         xIOSTALL_P,
  output logic         xIOERR_P,
  input  logic         xIOERRCLR_P,
  portio_ctl_if.master io
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);
  localparam logic [7:0]  TmoLast = 8'(TMO - 1);

  typedef enum logic [1:0] {StIdle, StWr, StRd, StDone} state_e;

  state_e         stateQ, stateD;
  logic [7:0]     tmoQ, tmoD;
  logic [AW-1:0]  wrPtrQ, rdPtrQ;
  logic [AW:0]    countQ;
  logic [15:0]    fifoMem [DEPTH];
  logic [15:0]    head;
  logic           ioWrQ, ioWrD;
  logic           ioRdQ, ioRdD;
  logic [7:0]     ioPortidQ, ioPortidD;
  logic [7:0]     ioOutQ, ioOutD;
  logic [7:0]     inportQ, inportD;
  logic           errQ;
  logic           errSet;
  logic           push, pop;
  logic           full, empty;
  logic           extRd, rdDone;
  logic           unusedNHigh;

  assign unusedNHigh = ^xN_P[7:3];

  assign full   = (countQ == FullCnt);
  assign empty  = (countQ == '0);
  assign extRd  = xINPUT_P & (xN_P[2:0] == 3'd0);
  assign rdDone = (stateQ == StDone);
  assign push   = xOUTPUT_P & ~full;
  assign head   = fifoMem[rdPtrQ];

  assign xIOSTALL_P = (xOUTPUT_P & full) | (extRd & ~rdDone);

  always_comb begin
    stateD    = stateQ;
    tmoD      = tmoQ;
    ioWrD     = 1'b0;
    ioRdD     = 1'b0;
    ioPortidD = ioPortidQ;
    ioOutD    = ioOutQ;
    inportD   = inportQ;
    errSet    = 1'b0;
    pop       = 1'b0;
    unique case (stateQ)
      StIdle: begin
        // Drain every buffered write before a read to keep program order.
        if (!empty) begin
          stateD    = StWr;
          ioWrD     = 1'b1;
          ioPortidD = head[15:8];
          ioOutD    = head[7:0];
          tmoD      = '0;
        end else if (extRd && !xOUTPUT_P) begin
          stateD    = StRd;
          ioRdD     = 1'b1;
          ioPortidD = xPORTID_P;
          tmoD      = '0;
        end
      end
      StWr: begin
        if (io.IO_ACK) begin
          pop    = 1'b1;
          stateD = StIdle;
        end else if (tmoQ == TmoLast) begin
          pop    = 1'b1;
          errSet = 1'b1;
          stateD = StIdle;
        end else begin
          ioWrD = 1'b1;
          tmoD  = tmoQ + 8'd1;
        end
      end
      StRd: begin
        if (io.IO_ACK) begin
          inportD = io.IO_IN;
          stateD  = StDone;
        end else if (tmoQ == TmoLast) begin
          inportD = 8'hFF;
          errSet  = 1'b1;
          stateD  = StDone;
        end else begin
          ioRdD = 1'b1;
          tmoD  = tmoQ + 8'd1;
        end
      end
      StDone:  stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stateQ    <= StIdle;
      tmoQ      <= '0;
      wrPtrQ    <= '0;
      rdPtrQ    <= '0;
      countQ    <= '0;
      ioWrQ     <= 1'b0;
      ioRdQ     <= 1'b0;
      ioPortidQ <= '0;
      ioOutQ    <= '0;
      inportQ   <= '0;
      errQ      <= 1'b0;
    end else begin
      stateQ    <= stateD;
      tmoQ      <= tmoD;
      ioWrQ     <= ioWrD;
      ioRdQ     <= ioRdD;
      ioPortidQ <= ioPortidD;
      ioOutQ    <= ioOutD;
      inportQ   <= inportD;
      if (push) wrPtrQ <= wrPtrQ + 1'b1;
      if (pop)  rdPtrQ <= rdPtrQ + 1'b1;
      if (push && !pop) begin
        countQ <= countQ + 1'b1;
      end else if (pop && !push) begin
        countQ <= countQ - 1'b1;
      end
      // A new timeout wins over a simultaneous clear request.
      if (errSet) begin
        errQ <= 1'b1;
      end else if (xIOERRCLR_P) begin
        errQ <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) fifoMem[wrPtrQ] <= {xPORTID_P, xOUTPORT_P};
  end

  assign io.IO_WR     = ioWrQ;
  assign io.IO_RD     = ioRdQ;
  assign io.IO_PORTID = ioPortidQ;
  assign io.IO_OUT    = ioOutQ;
  assign xINPORT_P    = inportQ;
  assign xIOERR_P     = errQ;

endmodule

// File: tb/tb_portio_ctl.sv
// Scoreboard bench for portio_ctl: a bus responder ACKs strobes after a programmable delay
// and checks writes against a queue; reads are checked against queued expected data.
module tb_portio_ctl;
  localparam int DEPTH = 4;
  localparam int TMO   = 15;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       xOUTPUT_P = 1'b0;
  logic       xINPUT_P = 1'b0;
  logic [7:0] xN_P = 8'h00;
  logic [7:0] xPORTID_P = 8'h00;
  logic [7:0] xOUTPORT_P = 8'h00;
  logic [7:0] xINPORT_P;
  logic       xIOSTALL_P;
  logic       xIOERR_P;
  logic       xIOERRCLR_P = 1'b0;

  portio_ctl_if io ();

  portio_ctl #(.DEPTH(DEPTH), .TMO(TMO)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .xOUTPUT_P  (xOUTPUT_P),
    .xINPUT_P   (xINPUT_P),
    .xN_P       (xN_P),
    .xPORTID_P  (xPORTID_P),
    .xOUTPORT_P (xOUTPORT_P),
    .xINPORT_P  (xINPORT_P),
    .xIOSTALL_P (xIOSTALL_P),
    .xIOERR_P   (xIOERR_P),
    .xIOERRCLR_P(xIOERRCLR_P),
    .io         (io)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [15:0] wrQ[$];
  logic [7:0]  rdQ[$];
  logic [7:0]  rdPort = 8'h00;
  int ackAfter = 2;
  int strobeCyc = 0;
  int lastLen = 0;
  int idleGap = 0;
  int wrDone = 0;
  int lastPushCyc = 0;
  bit wasStrobe = 0;
  bit gapChk = 0;
  logic [15:0] expWr;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Peripheral model: ACK in the ackAfter-th strobe cycle (0 = never).
  initial io.IO_ACK = 1'b0;
  initial io.IO_IN = 8'h00;
  always @(negedge CLK) begin
    if (RST) begin
      strobeCyc = 0;
      wasStrobe = 0;
      io.IO_ACK = 1'b0;
    end else if (io.IO_WR || io.IO_RD) begin
      if (!wasStrobe && gapChk && io.IO_WR) checkVal("wr_gap", idleGap, 1);
      wasStrobe = 1;
      idleGap = 0;
      strobeCyc++;
      io.IO_ACK = (strobeCyc == ackAfter);
      if (io.IO_ACK && io.IO_WR) begin
        if (wrQ.size() > 0) expWr = wrQ.pop_front();
        else expWr = 16'hxxxx;
        checkVal("wr_data", {16'h0, io.IO_PORTID, io.IO_OUT}, {16'h0, expWr});
        wrDone++;
      end
      if (io.IO_ACK && io.IO_RD) checkVal("rd_port", io.IO_PORTID, rdPort);
    end else begin
      if (wasStrobe) lastLen = strobeCyc;
      wasStrobe = 0;
      strobeCyc = 0;
      idleGap++;
      io.IO_ACK = 1'b0;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return io.IO_WR;
      1:       return io.IO_RD;
      default: return xIOSTALL_P;
    endcase
  endfunction

  task automatic waitSig(input int which, input logic level, input string tag);
    for (int i = 0; i < 300; i++) begin
      if (sig(which) === level) return;
      tick();
      #1;
    end
    checkVal(tag, sig(which), level);
  endtask

  task automatic waitWrites(input int target, input string tag);
    for (int i = 0; i < 300 && wrDone < target; i++) begin
      tick();
      #1;
    end
    checkVal(tag, wrDone, target);
  endtask

  task automatic doWrite(input logic [7:0] port, input logic [7:0] data, output int stalls);
    stalls = 0;
    xOUTPUT_P = 1'b1;
    xPORTID_P = port;
    xOUTPORT_P = data;
    #1;
    for (int i = 0; i < 300 && xIOSTALL_P; i++) begin
      stalls++;
      tick();
      #1;
    end
    checkVal("wr_accept", xIOSTALL_P, 0);
    wrQ.push_back({port, data});
    lastPushCyc = cyc;
    tick();
    xOUTPUT_P = 1'b0;
    #1;
  endtask

  task automatic doRead(input logic [7:0] port, input logic [7:0] nSel, input logic [7:0] inVal,
                        input logic [7:0] expData, input int expStall, input int expWrBefore);
    int stalls;
    int base;
    bit seen;
    stalls = 0;
    seen = 0;
    base = wrDone;
    rdQ.push_back(expData);
    rdPort = port;
    io.IO_IN = inVal;
    xINPUT_P = 1'b1;
    xN_P = nSel;
    xPORTID_P = port;
    #1;
    for (int i = 0; i < 300 && xIOSTALL_P; i++) begin
      if (io.IO_RD && !seen && expWrBefore >= 0) begin
        seen = 1;
        checkVal("rd_order", wrDone - base, expWrBefore);
      end
      stalls++;
      tick();
      #1;
    end
    checkVal("rd_stall_rel", xIOSTALL_P, 0);
    checkVal("rd_data", xINPORT_P, rdQ.pop_front());
    if (expStall >= 0) checkVal("rd_stall_len", stalls, expStall);
    if (expWrBefore >= 0) checkVal("rd_seen", seen, 1);
    tick();
    xINPUT_P = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int base;
    repeat (3) tick();
    #1;
    checkVal("rst_wr", io.IO_WR, 0);
    checkVal("rst_rd", io.IO_RD, 0);
    checkVal("rst_portid", io.IO_PORTID, 0);
    checkVal("rst_out", io.IO_OUT, 0);
    checkVal("rst_inport", xINPORT_P, 8'h00);
    checkVal("rst_err", xIOERR_P, 0);
    checkVal("rst_stall", xIOSTALL_P, 0);
    RST = 1'b0;
    tick();
    #1;

    // Single write: strobe two cycles after the push, ACK on the second strobe cycle.
    ackAfter = 2;
    doWrite(8'h12, 8'hA5, st);
    checkVal("wr1_stall", st, 0);
    waitSig(0, 1'b1, "wr1_start");
    checkVal("wr1_lat", cyc - lastPushCyc, 2);
    checkVal("wr1_portid", io.IO_PORTID, 8'h12);
    checkVal("wr1_out", io.IO_OUT, 8'hA5);
    waitSig(0, 1'b0, "wr1_end");
    checkVal("wr1_empty", dut.countQ, 0);
    tick();
    #1;
    checkVal("wr1_len", lastLen, 2);

    // Fill the buffer: the fifth write stalls until the first ACK.
    ackAfter = 3;
    base = wrDone;
    doWrite(8'h20, 8'h01, st);
    doWrite(8'h21, 8'h02, st);
    doWrite(8'h22, 8'h03, st);
    gapChk = 1;
    doWrite(8'h23, 8'h04, st);
    checkVal("fill_nostall4", st, 0);
    doWrite(8'h24, 8'h05, st);
    checkVal("fill_stall", st, 1);
    checkVal("fill_first_ack", wrDone - base, 1);
    waitWrites(base + 5, "fill_done");
    gapChk = 0;
    repeat (2) tick();
    #1;

    // Read behind two pending writes.
    ackAfter = 2;
    base = wrDone;
    doWrite(8'h30, 8'hB1, st);
    doWrite(8'h31, 8'hB2, st);
    doRead(8'h77, 8'h00, 8'h3C, 8'h3C, -1, 2);
    checkVal("rdw_hold", xINPORT_P, 8'h3C);

    // Isolated read: stall lasts request cycle plus strobe cycles.
    doRead(8'h78, 8'h08, 8'hC3, 8'hC3, 3, -1);

    // Read timeout: strobe for TMO cycles, FF returned, sticky error.
    ackAfter = 0;
    doRead(8'h40, 8'h00, 8'h11, 8'hFF, TMO + 1, -1);
    checkVal("tmo_len", lastLen, TMO);
    checkVal("tmo_err", xIOERR_P, 1);
    repeat (3) tick();
    #1;
    checkVal("tmo_err_hold", xIOERR_P, 1);
    xIOERRCLR_P = 1'b1;
    tick();
    xIOERRCLR_P = 1'b0;
    #1;
    checkVal("tmo_err_clr", xIOERR_P, 0);

    // ACK in the final allowed strobe cycle is a success.
    ackAfter = TMO;
    doRead(8'h41, 8'h00, 8'h5A, 8'h5A, TMO + 1, -1);
    checkVal("tmo_edge_err", xIOERR_P, 0);

    // Internal input never touches the bus.
    xINPUT_P = 1'b1;
    xN_P = 8'h03;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkVal("int_stall", xIOSTALL_P, 0);
      checkVal("int_rd", io.IO_RD, 0);
      tick();
      #1;
    end
    checkVal("int_hold", xINPORT_P, 8'h5A);
    xINPUT_P = 1'b0;
    xN_P = 8'h00;
    #1;

    // Reset during an outstanding read.
    ackAfter = 0;
    xPORTID_P = 8'h55;
    xINPUT_P = 1'b1;
    #1;
    waitSig(1, 1'b1, "rst_rd_start");
    RST = 1'b1;
    tick();
    #1;
    checkVal("rstm_rd", io.IO_RD, 0);
    checkVal("rstm_stall", xIOSTALL_P, 1);
    checkVal("rstm_count", dut.countQ, 0);
    checkVal("rstm_inport", xINPORT_P, 8'h00);
    RST = 1'b0;
    xINPUT_P = 1'b0;
    #1;
    checkVal("rstm_stall_off", xIOSTALL_P, 0);

    // Controller recovers after reset.
    ackAfter = 1;
    base = wrDone;
    doWrite(8'h9A, 8'h5C, st);
    waitWrites(base + 1, "post_rst_wr");
    checkVal("sb_drained", wrQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
